// File: rtl/led_ctrl_pkg.sv
// rtl/led_ctrl_pkg.sv - shared encodings for the LED counter controller
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_BIN   = 2'd0,
    MODE_GRAY  = 2'd1,
    MODE_INV   = 2'd2,
    MODE_BLINK = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_e;

  localparam int KEY_UP   = 0;
  localparam int KEY_DN   = 1;
  localparam int KEY_MODE = 2;

endpackage

// File: rtl/led_pattern_enc.sv
// rtl/led_pattern_enc.sv - combinational count/mode/blink to LED pattern encoder
module led_pattern_enc
  import led_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_count,
  input  mode_e            i_mode,
  input  logic             i_blink_phase,
  output logic [WIDTH-1:0] o_pattern
);

  always_comb begin
    o_pattern = i_count;
    case (i_mode)
      MODE_BIN:   o_pattern = i_count;
      MODE_GRAY:  o_pattern = i_count ^ (i_count >> 1);
      MODE_INV:   o_pattern = ~i_count;
      MODE_BLINK: o_pattern = i_blink_phase ? i_count : '0;
      default:    o_pattern = i_count;
    endcase
  end

endmodule

// File: rtl/led_counter_ctrl.sv
// rtl/led_counter_ctrl.sv - up/down/mode key counter with auto-repeat and LED display patterns
module led_counter_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int SATURATE   = 0,
  parameter int HOLD_CYC   = 25_000_000,
  parameter int REPEAT_CYC = 5_000_000,
  parameter int BLINK_CYC  = 12_500_000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [2:0]       i_key_flag,
  input  logic [2:0]       i_key_state,
  output logic [WIDTH-1:0] o_led,
  output logic [WIDTH-1:0] o_count,
  output logic [1:0]       o_mode,
  output logic             o_repeat_active
);

  localparam int TMR_W = $clog2((HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC);
  localparam int BLK_W = $clog2(BLINK_CYC);
  localparam logic [TMR_W-1:0] HOLD_LAST   = TMR_W'(HOLD_CYC - 1);
  localparam logic [TMR_W-1:0] REPEAT_LAST = TMR_W'(REPEAT_CYC - 1);
  localparam logic [BLK_W-1:0] BLINK_LAST  = BLK_W'(BLINK_CYC - 1);
  localparam logic [WIDTH-1:0] ONE         = WIDTH'(1);

  state_e           r_state;
  mode_e            r_mode;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_led;
  logic [TMR_W-1:0] r_tmr;
  logic             r_dir_up;
  logic             r_repeat_active;
  logic [BLK_W-1:0] r_blink_cnt;
  logic             r_blink_phase;

  logic             w_press_up;
  logic             w_press_dn;
  logic             w_press_dir;
  logic             w_press_any;
  logic             w_mode_press;
  logic             w_dir_release;
  logic             w_tmr_done;
  logic [WIDTH-1:0] w_pattern;

  // Up wins a simultaneous up/down press; the down event is dropped entirely.
  assign w_press_up    = i_key_flag[KEY_UP] && !i_key_state[KEY_UP];
  assign w_press_dn    = i_key_flag[KEY_DN] && !i_key_state[KEY_DN];
  assign w_press_any   = w_press_up || w_press_dn;
  assign w_press_dir   = w_press_up;
  assign w_mode_press  = i_key_flag[KEY_MODE] && !i_key_state[KEY_MODE];
  assign w_dir_release = r_dir_up ? (i_key_flag[KEY_UP] && i_key_state[KEY_UP])
                                  : (i_key_flag[KEY_DN] && i_key_state[KEY_DN]);
  assign w_tmr_done    = (r_state == HOLD) ? (r_tmr == HOLD_LAST) : (r_tmr == REPEAT_LAST);

  function automatic logic [WIDTH-1:0] f_step(input logic [WIDTH-1:0] cnt, input logic up);
    if (up) begin
      if ((SATURATE != 0) && (cnt == '1)) return cnt;
      return cnt + ONE;
    end
    if ((SATURATE != 0) && (cnt == '0)) return cnt;
    return cnt - ONE;
  endfunction

  led_pattern_enc #(.WIDTH(WIDTH)) u_pattern_enc (
    .i_count       (r_count),
    .i_mode        (r_mode),
    .i_blink_phase (r_blink_phase),
    .o_pattern     (w_pattern)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (r_blink_cnt == BLINK_LAST) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= ~r_blink_phase;
    end else begin
      r_blink_cnt   <= r_blink_cnt + BLK_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state         <= IDLE;
      r_mode          <= MODE_BIN;
      r_count         <= '0;
      r_led           <= '0;
      r_tmr           <= '0;
      r_dir_up        <= 1'b0;
      r_repeat_active <= 1'b0;
    end else begin
      r_led <= w_pattern;
      if (w_mode_press) r_mode <= mode_e'(r_mode + 2'd1);
      case (r_state)
        IDLE: begin
          r_repeat_active <= 1'b0;
          if (w_press_any) begin
            r_count  <= f_step(r_count, w_press_dir);
            r_dir_up <= w_press_dir;
            r_tmr    <= '0;
            r_state  <= HOLD;
          end
        end
        HOLD, REPEAT: begin
          // A fresh press of the held direction carries no new information; the timer runs on.
          if (w_press_any && (w_press_dir != r_dir_up)) begin
            r_count         <= f_step(r_count, w_press_dir);
            r_dir_up        <= w_press_dir;
            r_tmr           <= '0;
            r_state         <= HOLD;
            r_repeat_active <= 1'b0;
          end else if (w_dir_release) begin
            r_tmr           <= '0;
            r_state         <= IDLE;
            r_repeat_active <= 1'b0;
          end else if (w_tmr_done) begin
            r_count         <= f_step(r_count, r_dir_up);
            r_tmr           <= '0;
            r_state         <= REPEAT;
            r_repeat_active <= (r_state == REPEAT);
          end else begin
            r_tmr           <= r_tmr + TMR_W'(1);
            r_repeat_active <= (r_state == REPEAT);
          end
        end
        default: begin
          r_state         <= IDLE;
          r_tmr           <= '0;
          r_repeat_active <= 1'b0;
        end
      endcase
    end
  end

  assign o_led           = r_led;
  assign o_count         = r_count;
  assign o_mode          = r_mode;
  assign o_repeat_active = r_repeat_active;

endmodule

// File: tb/tb_led_counter_ctrl.sv
// tb/tb_led_counter_ctrl.sv - randomized check of wrap and saturate builds against a cycle-schedule model
module tb_led_counter_ctrl;

  localparam int W      = 4;
  localparam int HOLD   = 8;
  localparam int REP    = 4;
  localparam int BLINK  = 4;
  localparam int MAXC   = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   key_flag;
  logic [2:0]   key_state;
  logic [W-1:0] led_w, led_s, cnt_w, cnt_s;
  logic [1:0]   mode_w, mode_s;
  logic         ra_w, ra_s;

  always #5 clk = ~clk;

  led_counter_ctrl #(.WIDTH(W), .SATURATE(0), .HOLD_CYC(HOLD), .REPEAT_CYC(REP), .BLINK_CYC(BLINK)) u_dut_wrap (
    .i_clk(clk), .i_rst(rst), .i_key_flag(key_flag), .i_key_state(key_state),
    .o_led(led_w), .o_count(cnt_w), .o_mode(mode_w), .o_repeat_active(ra_w)
  );

  led_counter_ctrl #(.WIDTH(W), .SATURATE(1), .HOLD_CYC(HOLD), .REPEAT_CYC(REP), .BLINK_CYC(BLINK)) u_dut_sat (
    .i_clk(clk), .i_rst(rst), .i_key_flag(key_flag), .i_key_state(key_state),
    .o_led(led_s), .o_count(cnt_s), .o_mode(mode_s), .o_repeat_active(ra_s)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: absolute edge numbers instead of a timer; held = 0 none, 1 up, 2 down.
  int         m_count [2];
  int         m_led   [2];
  int         m_mode, m_held, m_edges, m_press_edge, m_next_step;
  bit         m_ra;
  logic [2:0] lv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, m_edges);
    end
  endtask

  function automatic int mstep(input int c, input bit up, input bit sat);
    if (up) return (sat && c == MAXC) ? c : (c + 1) % (MAXC + 1);
    return (sat && c == 0) ? c : (c + MAXC) % (MAXC + 1);
  endfunction

  function automatic int mpat(input int c, input int md, input bit ph);
    case (md)
      0:       return c;
      1:       return c ^ (c >> 1);
      2:       return MAXC - c;
      default: return ph ? c : 0;
    endcase
  endfunction

  task automatic model_reset();
    m_count = '{0, 0};
    m_led   = '{0, 0};
    m_mode = 0; m_held = 0; m_edges = 0; m_press_edge = 0; m_next_step = 0; m_ra = 0;
  endtask

  task automatic model_edge(input logic [2:0] f, input logic [2:0] s);
    bit pu, pd, ph;
    int pdir;
    ph = ((m_edges / BLINK) % 2) == 1;
    for (int k = 0; k < 2; k++) m_led[k] = mpat(m_count[k], m_mode, ph);
    m_edges++;
    pu   = f[0] && !s[0];
    pd   = f[1] && !s[1] && !pu;
    pdir = pu ? 1 : 2;
    if (f[2] && !s[2]) m_mode = (m_mode + 1) % 4;
    if ((pu || pd) && pdir != m_held) begin
      for (int k = 0; k < 2; k++) m_count[k] = mstep(m_count[k], pu, k == 1);
      m_held       = pdir;
      m_press_edge = m_edges;
      m_next_step  = m_edges + HOLD;
    end else if (m_held != 0 && f[m_held-1] && s[m_held-1]) begin
      m_held = 0;
    end else if (m_held != 0 && m_edges == m_next_step) begin
      for (int k = 0; k < 2; k++) m_count[k] = mstep(m_count[k], m_held == 1, k == 1);
      m_next_step += REP;
    end
    m_ra = (m_held != 0) && (m_edges > m_press_edge + HOLD);
  endtask

  task automatic check_all();
    chk("count_wrap", cnt_w, m_count[0]);
    chk("count_sat",  cnt_s, m_count[1]);
    chk("led_wrap",   led_w, m_led[0]);
    chk("led_sat",    led_s, m_led[1]);
    chk("mode_wrap",  mode_w, m_mode);
    chk("mode_sat",   mode_s, m_mode);
    chk("ra_wrap",    ra_w, m_ra);
    chk("ra_sat",     ra_s, m_ra);
  endtask

  task automatic tick(input logic r, input logic [2:0] f);
    rst       = r;
    key_flag  = f;
    key_state = lv;
    @(posedge clk);
    if (r) model_reset();
    else   model_edge(f, lv);
    #1;
    check_all();
    rst      = 1'b0;
    key_flag = 3'b000;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 3'b000);
  endtask

  task automatic press(input int k);
    lv[k] = 1'b0;
    tick(1'b0, 3'(1 << k));
  endtask

  task automatic release_key(input int k);
    lv[k] = 1'b1;
    tick(1'b0, 3'(1 << k));
  endtask

  initial begin
    logic [2:0] f;
    lv = 3'b111; rst = 1'b1; key_flag = 3'b000; key_state = 3'b111;
    tick(1'b1, 3'b000);
    chk("rst_count", cnt_w, 0);
    chk("rst_led",   led_w, 0);
    chk("rst_ra",    ra_w, 0);

    for (int i = 0; i < 3; i++) begin
      press(0); idle(2); release_key(0); idle(2);
    end
    chk("three_up_count", cnt_w, 3);
    chk("three_up_led",   led_w, 4'b0011);
    press(2); release_key(2); idle(1);
    chk("gray_led", led_w, 4'b0010);

    tick(1'b1, 3'b000);
    press(0); idle(19);
    chk("hold_count", cnt_w, 4);
    chk("hold_ra",    ra_w, 1);
    release_key(0);
    chk("rel_ra",    ra_w, 0);
    idle(10);
    chk("rel_frozen", cnt_w, 4);

    tick(1'b1, 3'b000);
    press(1);
    chk("down_wrap", cnt_w, 15);
    chk("down_sat",  cnt_s, 0);
    release_key(1);
    press(0);
    chk("up_wrap", cnt_w, 0);
    chk("up_sat",  cnt_s, 1);
    idle(14);
    tick(1'b1, 3'b000);
    idle(12);
    chk("rst_held_count", cnt_w, 0);
    release_key(0);

    for (int i = 0; i < 3000; i++) begin
      f = 3'b000;
      for (int k = 0; k < 3; k++) begin
        if ($urandom_range(0, 11) == 0) begin
          f[k]  = 1'b1;
          lv[k] = ~lv[k];
        end
      end
      tick($urandom_range(0, 499) == 0, f);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
